// File: rtl/gcd_stein_pkg.sv
// Shared definitions for the binary (Stein) GCD engine: state encoding,
// default operand width and the shift/cycle counter width formula.
package gcd_stein_pkg;

  localparam int unsigned GCD_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REDUCE = 2'd1,
    FINISH = 2'd2
  } gcd_state_e;

  // Wide enough for the power-of-two count k and for up to 2*WIDTH+1 REDUCE cycles.
  function automatic int unsigned gcd_cntw(input int unsigned width);
    return $clog2(2 * width + 2);
  endfunction

endpackage

// File: rtl/gcd_stein_step.sv
// One combinational Stein reduction step; kept separate so an unrolled
// multi-step-per-cycle engine can chain several of these.
module gcd_stein_step
  import gcd_stein_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH,
  parameter int unsigned CNTW  = gcd_cntw(GCD_WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [CNTW-1:0]  k,
  output logic [WIDTH-1:0] a_nxt_c,
  output logic [WIDTH-1:0] b_nxt_c,
  output logic [CNTW-1:0]  k_nxt_c,
  output logic             term_c
);

  logic term;

  assign term   = (a == '0) || (b == '0);
  assign term_c = term;

  // Priority: zero operand, both even, one even, both odd (subtract smaller).
  always_comb begin
    a_nxt_c = a;
    b_nxt_c = b;
    k_nxt_c = k;
    if (term) begin
      a_nxt_c = a;
    end else if (!a[0] && !b[0]) begin
      a_nxt_c = a >> 1;
      b_nxt_c = b >> 1;
      k_nxt_c = k + CNTW'(1);
    end else if (!a[0]) begin
      a_nxt_c = a >> 1;
    end else if (!b[0]) begin
      b_nxt_c = b >> 1;
    end else if (a >= b) begin
      a_nxt_c = (a - b) >> 1;
    end else begin
      b_nxt_c = (b - a) >> 1;
    end
  end

endmodule

// File: rtl/gcd_stein.sv
// Multiplier-free binary GCD engine with start/done handshake, one step per clock.
// Define GCD_CYCLES_EN to add the cycles output reporting REDUCE cycles used.
module gcd_stein
  import gcd_stein_pkg::*;
#(
  parameter int unsigned WIDTH = GCD_WIDTH,
  parameter int unsigned CNTW  = gcd_cntw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             coprime
`ifdef GCD_CYCLES_EN
  ,
  output logic [CNTW-1:0]  cycles
`endif
);

  gcd_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CNTW-1:0]  k_q, k_d;
  logic             busy_d, done_d, coprime_d;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] step_a, step_b, shifted;
  logic [CNTW-1:0]  step_k;
  logic             step_term;
`ifdef GCD_CYCLES_EN
  logic [CNTW-1:0]  cnt_q, cnt_d, cycles_d;
`endif

  gcd_stein_step #(
    .WIDTH (WIDTH),
    .CNTW  (CNTW)
  ) u_step (
    .a       (a_q),
    .b       (b_q),
    .k       (k_q),
    .a_nxt_c (step_a),
    .b_nxt_c (step_b),
    .k_nxt_c (step_k),
    .term_c  (step_term)
  );

  // One of a/b is zero at FINISH, so the OR is the odd survivor; k < WIDTH keeps all bits.
  assign shifted = (a_q | b_q) << k_q;

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    k_d       = k_q;
    busy_d    = busy;
    done_d    = 1'b0;
    result_d  = result;
    coprime_d = coprime;
`ifdef GCD_CYCLES_EN
    cnt_d     = cnt_q;
    cycles_d  = cycles;
`endif
    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          a_d     = ina;
          b_d     = inb;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = REDUCE;
`ifdef GCD_CYCLES_EN
          cnt_d   = '0;
`endif
        end
      end
      REDUCE: begin
        a_d = step_a;
        b_d = step_b;
        k_d = step_k;
        if (step_term) begin
          state_d = FINISH;
        end
`ifdef GCD_CYCLES_EN
        cnt_d = cnt_q + CNTW'(1);
`endif
      end
      FINISH: begin
        result_d  = shifted;
        coprime_d = (shifted == WIDTH'(1));
        done_d    = 1'b1;
        busy_d    = 1'b0;
        state_d   = IDLE;
`ifdef GCD_CYCLES_EN
        cycles_d  = cnt_q;
`endif
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      k_q     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      coprime <= 1'b0;
`ifdef GCD_CYCLES_EN
      cnt_q   <= '0;
      cycles  <= '0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      k_q     <= k_d;
      busy    <= busy_d;
      done    <= done_d;
      result  <= result_d;
      coprime <= coprime_d;
`ifdef GCD_CYCLES_EN
      cnt_q   <= cnt_d;
      cycles  <= cycles_d;
`endif
    end
  end

endmodule

// File: tb/tb_gcd_stein.sv
// Scoreboard bench for gcd_stein: driver queues Euclid-model results, a
// negedge monitor pops and checks them on every done pulse.
module tb_gcd_stein;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = $clog2(2 * W + 2);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] ina = '0;
  logic [W-1:0] inb = '0;
  logic         busy, done, coprime;
  logic [W-1:0] result;
`ifdef GCD_CYCLES_EN
  logic [CW-1:0] cycles;
`endif

  gcd_stein #(.WIDTH(W), .CNTW(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .ina     (ina),
    .inb     (inb),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .coprime (coprime)
`ifdef GCD_CYCLES_EN
    ,
    .cycles  (cycles)
`endif
  );

  always #5 clk = ~clk;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held_res = '0;
  logic         held_cop = 1'b0;
  logic         prev_done = 1'b0;

  // Reference: plain Euclid with modulo, independent of the binary algorithm.
  function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] t;
    while (y != '0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop on done, otherwise the last result must be held.
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (!rst_n) begin
      held_res  = '0;
      held_cop  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check("done_one_cycle", 64'(prev_done), 64'd0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_done: result 0x%0h with nothing outstanding", result);
        end else begin
          e = exp_q.pop_front();
          check("result", 64'(result), 64'(e));
          check("coprime", 64'(coprime), 64'(e == W'(1)));
          held_res = e;
          held_cop = (e == W'(1));
`ifdef GCD_CYCLES_EN
          check("cycles_bound", 64'(cycles <= CW'(2 * W)), 64'd1);
`endif
        end
      end else begin
        check("hold_result", 64'(result), 64'(held_res));
        check("hold_coprime", 64'(coprime), 64'(held_cop));
      end
      prev_done = done;
    end
  end

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 4 * W) begin
      @(negedge clk);
      t++;
    end
    check("idle_before_start", 64'(busy), 64'd0);
  endtask

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    ina   = a;
    inb   = b;
    start = 1'b1;
    exp_q.push_back(ref_gcd(a, b));
    @(posedge clk);
    #1;
    start = 1'b0;
    ina   = W'($urandom);
    inb   = W'($urandom);
  endtask

  task automatic wait_done(input int maxlat);
    int lat = 0;
    bit got = 0;
    while (!got && lat < maxlat + 5) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done) got = 1;
    end
    n_cmp++;
    if (!got || lat > maxlat) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles (done seen=%0d), required <= %0d", lat, got, maxlat);
    end
  endtask

  task automatic run(input logic [W-1:0] a, input logic [W-1:0] b, input int maxlat);
    wait_idle();
    issue(a, b);
    wait_done(maxlat);
  endtask

  initial begin
    logic [W-1:0] x, y;
    int r;
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_coprime", 64'(coprime), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run(W'(48), W'(18), 2 * W + 1);
    run(W'(0), W'(0), 2);
    run(W'(0), W'(7), 2);
    run(W'(17), W'(0), 2);
    run(W'(65537), W'(3120), 2 * W + 1);
    run(W'(1) << 31, W'(1) << 20, 2 * W + 1);
    run(W'(32'hFFFF_FFFF), W'(32'hFFFF_FFFE), 2 * W + 1);
    run(W'(5), W'(5), 2 * W + 1);

    // Second start while busy must be ignored.
    wait_idle();
    issue(W'(12), W'(8));
    repeat (2) @(negedge clk);
    check("busy_mid_op", 64'(busy), 64'd1);
    ina   = W'(9);
    inb   = W'(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2 * W + 1);
    repeat (4) @(negedge clk);
    check("busy_after_ignored", 64'(busy), 64'd0);
    run(W'(9), W'(3), 2 * W + 1);

    // Reset mid-REDUCE aborts with no done.
    wait_idle();
    issue(W'(48), W'(18));
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_result", 64'(result), 64'd0);
    check("abort_coprime", 64'(coprime), 64'd0);
`ifdef GCD_CYCLES_EN
    check("abort_cycles", 64'(cycles), 64'd0);
`endif
    repeat (3) @(negedge clk);
    check("abort_no_done", 64'(done), 64'd0);
    rst_n = 1'b1;
    run(W'(21), W'(14), 2 * W + 1);

    // Random sweep over varied operand bit-lengths, with occasional zeros.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(1, W);
      x = W'($urandom) & (W'(32'hFFFF_FFFF) >> (W - r));
      r = $urandom_range(1, W);
      y = W'($urandom) & (W'(32'hFFFF_FFFF) >> (W - r));
      if ($urandom_range(0, 19) == 0) x = '0;
      if ($urandom_range(0, 19) == 0) y = '0;
      run(x, y, 2 * W + 1);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
